// File: rtl/cnn_weight_loader.sv
// Byte-serial weight loader: deserialises one input frame into feature, fully
// connected and bias chunks and strobes each chunk into its memory write port.
module cnn_weight_loader #(
  parameter int KERNEL_SIZE      = 4,
  parameter int NUM_FEATURES     = 3,
  parameter int FLATTENED_LENGTH = 432,
  parameter int FC_CHUNK         = 16,
  parameter int DATA_WIDTH       = 8
) (
  input  logic                                            clk,
  input  logic                                            rst_loader,
  input  logic                                            load_start,
  input  logic [DATA_WIDTH-1:0]                           in_data,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]   feature_weights_out,
  output logic [1:0]                                      feature_writeAddr,
  output logic                                            feature_WrEn,
  output logic [FC_CHUNK*DATA_WIDTH-1:0]                  fc_weights_out,
  output logic [$clog2(FLATTENED_LENGTH/FC_CHUNK)-1:0]    fc_writeAddr,
  output logic                                            fc_WrEn,
  output logic [(NUM_FEATURES+1)*DATA_WIDTH-1:0]          bias_weights_out,
  output logic                                            bias_WrEn,
  output logic                                            busy,
  output logic                                            done
);

  localparam int FEAT_BYTES  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int BIAS_BYTES  = NUM_FEATURES + 1;
  localparam int FC_CHUNKS   = FLATTENED_LENGTH / FC_CHUNK;
  localparam int FC_AW       = $clog2(FC_CHUNKS);
  localparam int MAX_FB      = (FEAT_BYTES > FC_CHUNK) ? FEAT_BYTES : FC_CHUNK;
  localparam int CHUNK_BYTES = (MAX_FB > BIAS_BYTES) ? MAX_FB : BIAS_BYTES;
  localparam int IDX_W       = $clog2(CHUNK_BYTES);

  localparam logic [IDX_W-1:0] FEAT_LAST_IDX  = IDX_W'(FEAT_BYTES - 1);
  localparam logic [IDX_W-1:0] FC_LAST_IDX    = IDX_W'(FC_CHUNK - 1);
  localparam logic [IDX_W-1:0] BIAS_LAST_IDX  = IDX_W'(BIAS_BYTES - 1);
  localparam logic [1:0]       FEAT_LAST_ADDR = 2'(NUM_FEATURES - 1);
  localparam logic [FC_AW-1:0] FC_LAST_ADDR   = FC_AW'(FC_CHUNKS - 1);

  typedef enum logic [2:0] {
    IDLE, FEAT, FEAT_WR, FC, FC_WR, BIAS, BIAS_WR, DONE
  } state_t;

  state_t                                 state_q, state_d;
  logic [IDX_W-1:0]                       byte_idx_q, byte_idx_d;
  logic [1:0]                             feat_cnt_q, feat_cnt_d;
  logic [FC_AW-1:0]                       fc_cnt_q, fc_cnt_d;
  logic [CHUNK_BYTES*DATA_WIDTH-1:0]      chunk_q, chunk_d;
  logic [FEAT_BYTES*DATA_WIDTH-1:0]       feat_data_q, feat_data_d;
  logic [1:0]                             feat_addr_q, feat_addr_d;
  logic [FC_CHUNK*DATA_WIDTH-1:0]         fc_data_q, fc_data_d;
  logic [FC_AW-1:0]                       fc_addr_q, fc_addr_d;
  logic [BIAS_BYTES*DATA_WIDTH-1:0]       bias_data_q, bias_data_d;
  logic                                   accept;

  assign in_ready = (state_q == FEAT) || (state_q == FC) || (state_q == BIAS);
  assign accept   = in_valid && in_ready;

  // Each lane captures the stream byte when the byte index points at it.
  // chunk_d already contains the final byte of a chunk, so the port output
  // registers can be loaded from it on the accepting edge.
  genvar gi;
  generate
    for (gi = 0; gi < CHUNK_BYTES; gi++) begin : g_lane
      assign chunk_d[gi*DATA_WIDTH +: DATA_WIDTH] =
        (accept && (byte_idx_q == IDX_W'(gi))) ? in_data
                                                : chunk_q[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    feat_cnt_d  = feat_cnt_q;
    fc_cnt_d    = fc_cnt_q;
    feat_data_d = feat_data_q;
    feat_addr_d = feat_addr_q;
    fc_data_d   = fc_data_q;
    fc_addr_d   = fc_addr_q;
    bias_data_d = bias_data_q;
    case (state_q)
      IDLE: begin
        byte_idx_d = '0;
        feat_cnt_d = '0;
        fc_cnt_d   = '0;
        if (load_start) state_d = FEAT;
      end
      FEAT: begin
        if (accept) begin
          if (byte_idx_q == FEAT_LAST_IDX) begin
            byte_idx_d  = '0;
            feat_data_d = chunk_d[FEAT_BYTES*DATA_WIDTH-1:0];
            feat_addr_d = feat_cnt_q;
            state_d     = FEAT_WR;
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end
        end
      end
      FEAT_WR: begin
        if (feat_cnt_q == FEAT_LAST_ADDR) begin
          feat_cnt_d = '0;
          state_d    = FC;
        end else begin
          feat_cnt_d = feat_cnt_q + 2'd1;
          state_d    = FEAT;
        end
      end
      FC: begin
        if (accept) begin
          if (byte_idx_q == FC_LAST_IDX) begin
            byte_idx_d = '0;
            fc_data_d  = chunk_d[FC_CHUNK*DATA_WIDTH-1:0];
            fc_addr_d  = fc_cnt_q;
            state_d    = FC_WR;
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end
        end
      end
      FC_WR: begin
        if (fc_cnt_q == FC_LAST_ADDR) begin
          fc_cnt_d = '0;
          state_d  = BIAS;
        end else begin
          fc_cnt_d = fc_cnt_q + FC_AW'(1);
          state_d  = FC;
        end
      end
      BIAS: begin
        if (accept) begin
          if (byte_idx_q == BIAS_LAST_IDX) begin
            byte_idx_d  = '0;
            bias_data_d = chunk_d[BIAS_BYTES*DATA_WIDTH-1:0];
            state_d     = BIAS_WR;
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end
        end
      end
      BIAS_WR: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_loader) begin
      state_q     <= IDLE;
      byte_idx_q  <= '0;
      feat_cnt_q  <= '0;
      fc_cnt_q    <= '0;
      chunk_q     <= '0;
      feat_data_q <= '0;
      feat_addr_q <= '0;
      fc_data_q   <= '0;
      fc_addr_q   <= '0;
      bias_data_q <= '0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      feat_cnt_q  <= feat_cnt_d;
      fc_cnt_q    <= fc_cnt_d;
      chunk_q     <= chunk_d;
      feat_data_q <= feat_data_d;
      feat_addr_q <= feat_addr_d;
      fc_data_q   <= fc_data_d;
      fc_addr_q   <= fc_addr_d;
      bias_data_q <= bias_data_d;
    end
  end

  // Strobes decode straight from the state register, so only one can be low.
  assign feature_WrEn        = (state_q != FEAT_WR);
  assign fc_WrEn             = (state_q != FC_WR);
  assign bias_WrEn           = (state_q != BIAS_WR);
  assign busy                = (state_q != IDLE);
  assign done                = (state_q == DONE);
  assign feature_weights_out = feat_data_q;
  assign feature_writeAddr   = feat_addr_q;
  assign fc_weights_out      = fc_data_q;
  assign fc_writeAddr        = fc_addr_q;
  assign bias_weights_out    = bias_data_q;

endmodule
